// File: rtl/data_memory_lsu.sv
// Load/store unit: one byte/half/word access per request, sub-word stores merged by read-modify-write.
// Optional feature macro: LSU_MISALIGN_EN (accesses spanning two words via read/write port 2).
module data_memory_lsu #(
   parameter int MEM_WORDS = 129
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [10:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_error_o,
   output logic [8:0]  mem_rd1_o,
   input  logic [31:0] mem_rd1_data_i,
   output logic [8:0]  mem_rd2_o,
   input  logic [31:0] mem_rd2_data_i,
   output logic [8:0]  mem_wr1_o,
   output logic [31:0] mem_wr1_data_o,
   output logic        mem_wr1_enable_o,
   output logic [8:0]  mem_wr2_o,
   output logic [31:0] mem_wr2_data_o,
   output logic        mem_wr2_enable_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   localparam logic [9:0] MemWordsL = 10'(MEM_WORDS);

   state_e      state_q;
   logic        write_q, signed_q, err_q, span_q;
   logic [1:0]  size_q, lane_q;
   logic [8:0]  word_q;
   logic [31:0] wdata_q;
   logic        resp_valid_q, resp_error_q;
   logic [31:0] resp_rdata_q;

   // Request decode, evaluated on the incoming request so the error is known before ACCESS
   logic [8:0]  in_word;
   logic [1:0]  in_lane;
   logic [9:0]  in_word_p1;
   logic        in_span_d, in_misalign_d, err_d, hs;

   assign in_word    = req_addr_i[10:2];
   assign in_lane    = req_addr_i[1:0];
   assign in_word_p1 = {1'b0, in_word} + 10'd1;
   assign hs         = req_valid_i && req_ready_o;

`ifdef LSU_MISALIGN_EN
   assign in_span_d     = (req_size_i == 2'b01 && in_lane == 2'd3) ||
                          (req_size_i == 2'b10 && in_lane != 2'd0);
   assign in_misalign_d = 1'b0;
`else
   assign in_span_d     = 1'b0;
   assign in_misalign_d = (req_size_i == 2'b01 && in_lane[0]) ||
                          (req_size_i == 2'b10 && in_lane != 2'd0);
`endif

   assign err_d = (req_size_i == 2'b11) || ({1'b0, in_word} >= MemWordsL) || in_misalign_d ||
                  (in_span_d && in_word_p1 >= MemWordsL);

   assign req_ready_o = (state_q == IDLE) || (state_q == RESP);

   // ACCESS datapath: treat rd2:rd1 as one 64-bit little-endian window starting at word_q
   logic        in_access, wr_go;
   logic [31:0] rd2_src, raw_d, mask32, ext_d;
   logic [63:0] rd_cat, mask64, data64, merged;
   logic [5:0]  shamt;

   assign in_access = (state_q == ACCESS);
   assign wr_go     = in_access && write_q && !err_q;
`ifdef LSU_MISALIGN_EN
   assign rd2_src = mem_rd2_data_i;
`else
   assign rd2_src = 32'd0;
`endif
   assign rd_cat = {rd2_src, mem_rd1_data_i};
   assign shamt  = {1'b0, lane_q, 3'b000};
   assign raw_d  = 32'(rd_cat >> shamt);

   always_comb begin
      mask32 = 32'hFFFF_FFFF;
      ext_d  = raw_d;
      case (size_q)
         2'b00: begin
            mask32 = 32'h0000_00FF;
            ext_d  = {{24{signed_q & raw_d[7]}}, raw_d[7:0]};
         end
         2'b01: begin
            mask32 = 32'h0000_FFFF;
            ext_d  = {{16{signed_q & raw_d[15]}}, raw_d[15:0]};
         end
         default: ;
      endcase
   end

   assign mask64 = {32'd0, mask32} << shamt;
   assign data64 = {32'd0, wdata_q & mask32} << shamt;
   assign merged = (rd_cat & ~mask64) | data64;

   assign mem_rd1_o        = in_access ? word_q : 9'd0;
   assign mem_wr1_o        = wr_go ? word_q : 9'd0;
   assign mem_wr1_data_o   = wr_go ? merged[31:0] : 32'd0;
   assign mem_wr1_enable_o = wr_go;

`ifdef LSU_MISALIGN_EN
   assign mem_rd2_o        = in_access ? (word_q + 9'd1) : 9'd0;
   assign mem_wr2_o        = (wr_go && span_q) ? (word_q + 9'd1) : 9'd0;
   assign mem_wr2_data_o   = (wr_go && span_q) ? merged[63:32] : 32'd0;
   assign mem_wr2_enable_o = wr_go && span_q;
`else
   logic unused_hi;
   assign unused_hi        = ^{mem_rd2_data_i, merged[63:32], span_q, in_word_p1};
   assign mem_rd2_o        = 9'd0;
   assign mem_wr2_o        = 9'd0;
   assign mem_wr2_data_o   = 32'd0;
   assign mem_wr2_enable_o = 1'b0;
`endif

   assign resp_valid_o = resp_valid_q;
   assign resp_rdata_o = resp_rdata_q;
   assign resp_error_o = resp_error_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         signed_q     <= 1'b0;
         err_q        <= 1'b0;
         span_q       <= 1'b0;
         size_q       <= 2'b00;
         lane_q       <= 2'b00;
         word_q       <= 9'd0;
         wdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_rdata_q <= 32'd0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         if (hs) begin
            write_q  <= req_write_i;
            size_q   <= req_size_i;
            signed_q <= req_signed_i;
            lane_q   <= in_lane;
            word_q   <= in_word;
            wdata_q  <= req_wdata_i;
            err_q    <= err_d;
            span_q   <= in_span_d;
         end
         case (state_q)
            IDLE:    state_q <= hs ? ACCESS : IDLE;
            ACCESS: begin
               state_q      <= RESP;
               resp_valid_q <= 1'b1;
               resp_error_q <= err_q;
               resp_rdata_q <= (write_q || err_q) ? 32'd0 : ext_d;
            end
            RESP:    state_q <= hs ? ACCESS : IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu with a 512-word behavioural memory; honours LSU_MISALIGN_EN.
module tb_data_memory_lsu;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [10:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid, resp_error;
   logic [31:0] resp_rdata;
   logic [8:0]  rd1, rd2, wr1, wr2;
   logic [31:0] rd1_data, rd2_data, wr1_data, wr2_data;
   logic        wr1_en, wr2_en;

   always #5 clk = ~clk;

   data_memory_lsu #(.MEM_WORDS(129)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_error_o(resp_error),
      .mem_rd1_o(rd1), .mem_rd1_data_i(rd1_data), .mem_rd2_o(rd2), .mem_rd2_data_i(rd2_data),
      .mem_wr1_o(wr1), .mem_wr1_data_o(wr1_data), .mem_wr1_enable_o(wr1_en),
      .mem_wr2_o(wr2), .mem_wr2_data_o(wr2_data), .mem_wr2_enable_o(wr2_en)
   );

   logic [31:0] mem [512];
   assign rd1_data = mem[rd1];
   assign rd2_data = mem[rd2];
   always @(posedge clk) begin
      if (wr1_en) mem[wr1] <= wr1_data;
      if (wr2_en) mem[wr2] <= wr2_data;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;
   exp_t sbq[$];
   logic [31:0] ref_mem [512];
   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && resp_valid) begin
         if (sbq.size() == 0) chk("resp_valid_unexp", {31'd0, resp_valid}, 32'd0);
         else begin
            e = sbq.pop_front();
            chk("rdata", resp_rdata, e.rdata);
            chk("error", {31'd0, resp_error}, {31'd0, e.err});
            chk("latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   function automatic logic model_err(input int sz, input int a);
      int w, nb;
      if (sz == 3) return 1'b1;
      w = a >> 2;
      if (w >= 129) return 1'b1;
      nb = 1 << sz;
`ifdef LSU_MISALIGN_EN
      begin
         int we;
         we = (a + nb - 1) >> 2;
         if (we != w && we >= 129) return 1'b1;
      end
`else
      if (a % nb != 0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [10:0] a, input logic [31:0] wd);
      int n = 0;
      exp_t e;
      logic [31:0] v;
      int ab, nb;
      @(negedge clk);
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (!req_ready) chk("ready_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      e.err = model_err(int'(sz), int'(a));
      e.cyc = cyc + 2;
      e.rdata = 32'd0;
      nb = 1 << sz;
      if (!e.err) begin
         v = 32'd0;
         for (int i = 0; i < nb; i++) begin
            ab = (int'(a) + i) & 'h7FF;
            if (wr) ref_mem[ab >> 2][8*(ab & 3) +: 8] = wd[8*i +: 8];
            else    v[8*i +: 8] = ref_mem[ab >> 2][8*(ab & 3) +: 8];
         end
         if (sg && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
         if (sg && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
         if (!wr) e.rdata = v;
      end
      sbq.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 10) begin @(negedge clk); n++; end
      chk("drain", 32'(sbq.size()), 32'd0);
   endtask

   logic [31:0] saved;

   initial begin
      for (int i = 0; i < 512; i++) ref_mem[i] = 32'd0;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 11'd0; req_wdata = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_wr1_en", {31'd0, wr1_en}, 32'd0);
      chk("rst_rd1", {23'd0, rd1}, 32'd0);
      rst_n = 1'b1;

      // basic word store then load
      do_req(1'b1, 2'd2, 1'b0, 11'h010, 32'hDEADBEEF);
      do_req(1'b0, 2'd2, 1'b0, 11'h010, 32'd0);
      drain();

      // byte merge and extension
      do_req(1'b1, 2'd2, 1'b0, 11'h010, 32'h11223344);
      do_req(1'b1, 2'd0, 1'b0, 11'h011, 32'h000000AA);
      drain();
      chk("mem4_merge", mem[4], 32'h1122AA44);
      do_req(1'b0, 2'd0, 1'b1, 11'h011, 32'd0);
      do_req(1'b0, 2'd0, 1'b0, 11'h011, 32'd0);

      // range boundary
      do_req(1'b1, 2'd2, 1'b0, 11'h200, 32'h5555AAAA);
      do_req(1'b0, 2'd2, 1'b0, 11'h200, 32'd0);
      drain();
      saved = mem[129];
      do_req(1'b0, 2'd2, 1'b0, 11'h204, 32'd0);
      do_req(1'b1, 2'd2, 1'b0, 11'h204, 32'h12345678);
      drain();
      chk("mem129_untouched", mem[129], saved);

      // misalignment (outcome follows the macro)
      do_req(1'b1, 2'd2, 1'b0, 11'h010, 32'hAB000000);
      do_req(1'b1, 2'd2, 1'b0, 11'h014, 32'h000000CD);
      do_req(1'b0, 2'd1, 1'b1, 11'h013, 32'd0);
      do_req(1'b0, 2'd1, 1'b0, 11'h011, 32'd0);
      do_req(1'b0, 2'd2, 1'b0, 11'h012, 32'd0);
      do_req(1'b1, 2'd1, 1'b0, 11'h013, 32'h00001234);
      do_req(1'b0, 2'd2, 1'b0, 11'h010, 32'd0);
      do_req(1'b0, 2'd2, 1'b0, 11'h014, 32'd0);
      do_req(1'b0, 2'd2, 1'b0, 11'h201, 32'd0);
      do_req(1'b0, 2'd3, 1'b0, 11'h018, 32'd0);
      drain();

      // reset during ACCESS cancels the store
      @(negedge clk);
      saved = mem[4];
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 11'h010;
      req_wdata = ~saved;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("t5_wen_access", {31'd0, wr1_en}, 32'd1);
      rst_n = 1'b0; #1;
      chk("t5_wen_dropped", {31'd0, wr1_en}, 32'd0);
      repeat (2) @(negedge clk);
      chk("t5_mem_unchanged", mem[4], saved);
      rst_n = 1'b1; #1;
      chk("t5_ready", {31'd0, req_ready}, 32'd1);
      chk("t5_resp_valid", {31'd0, resp_valid}, 32'd0);

      // back-to-back store then load in the store's RESP cycle
      do_req(1'b1, 2'd2, 1'b0, 11'h018, 32'hCAFEF00D);
      do_req(1'b0, 2'd2, 1'b0, 11'h018, 32'd0);
      do_req(1'b1, 2'd0, 1'b0, 11'h01A, 32'h0000005A);
      do_req(1'b0, 2'd2, 1'b0, 11'h018, 32'd0);
      drain();

      // random traffic over known-initialised words near both ends
      for (int i = 0; i < 10; i++) do_req(1'b1, 2'd2, 1'b0, 11'(4*i), $urandom);
      for (int i = 120; i < 132; i++) do_req(1'b1, 2'd2, 1'b0, 11'(4*i), $urandom);
      for (int i = 0; i < 40; i++) begin
         logic [10:0] ra;
         ra = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 'h27))
                                          : 11'($urandom_range('h1E0, 'h20F));
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ra, $urandom);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
